// File: rtl/mcp3008_pkg.sv
// Shared definitions for the MCP3008 emulator: FSM encoding, dclk pulse
// indices within a frame, and the power-on channel contents.
package mcp3008_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        CMD,
        NULLB,
        MSB,
        TAIL
    } state_e;

    localparam int NUM_CH = 8;
    localparam int CH_W   = 10;
    localparam int PW     = 5;

    // Pulse numbers count dclk rising edges, with the start bit as pulse 1
    localparam logic [PW-1:0] P_START   = 5'd1;
    localparam logic [PW-1:0] P_D0      = 5'd5;
    localparam logic [PW-1:0] P_NULL    = 5'd6;
    localparam logic [PW-1:0] P_B0      = 5'd16;
    localparam logic [PW-1:0] P_LSB_END = 5'd25;

    // Channel n powers up holding 128*n+5, so every channel reads back distinct
    function automatic logic [CH_W-1:0] ch_reset_val(input int n);
        return CH_W'(128 * n + 5);
    endfunction

endpackage

// File: rtl/mcp3008_sync_edge_detect.sv
// Multi-flop synchronizer for one asynchronous pin, followed by a history
// flop that turns level changes into single-clk rise/fall pulses.
module sync_edge_detect #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_i,
    output logic rise_o,
    output logic fall_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Resample the pin, then remember the previous synchronized level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o =  sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[SYNC_STAGES-1] &  prev_q;

endmodule

// File: rtl/mcp3008_emulator.sv
// MCP3008 SPI ADC emulator: decodes the start/SGL/D2..D0 command, then
// shifts back a 10-bit value taken from eight host-writable channel
// registers. Optional build macro MCP3008_EMU_LSB_FIRST_EN adds the
// LSB-first repeat (B1..B9) after B0; otherwise dout is 0 after B0.
module mcp3008_emulator
    import mcp3008_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs_n,
    input  logic       dclk,
    input  logic       din,
    output logic       dout,
    output logic       dout_oe,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [9:0] wr_data,
    output logic       conv_done,
    output logic [2:0] conv_ch,
    output logic       conv_sgl
);
    logic cs_rise, cs_fall, dclk_rise, dclk_fall;
    logic [SYNC_STAGES-1:0] din_sync_q;
    logic din_s;

    state_e                   state_q, state_d;
    logic [PW-1:0]            pulse_q, pulse_d;
    logic [3:0]               cmd_q, cmd_d;
    logic [CH_W-1:0]          sr_q, sr_d;
    logic                     dout_q, dout_d, oe_q, oe_d;
    logic                     done_q, done_d, sgl_q, sgl_d;
    logic [2:0]               ch_sel_q, ch_sel_d;
    logic [NUM_CH-1:0][CH_W-1:0] ch_q, ch_d;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk(clk), .rst_n(rst_n), .pin_i(cs_n), .rise_o(cs_rise), .fall_o(cs_fall)
    );

    // dclk edges only act outside IDLE, and every path with cs_n high
    // lands in IDLE, so no separate cs_n-level gating is needed.
    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_dclk_sync (
        .clk(clk), .rst_n(rst_n), .pin_i(dclk), .rise_o(dclk_rise), .fall_o(dclk_fall)
    );

    // din shares the dclk synchronizer depth so it lines up with dclk edges
    assign din_s = din_sync_q[SYNC_STAGES-1];

    // SGL returns the channel directly; DIFF subtracts the pair and clamps at 0
    function automatic logic [CH_W-1:0] conv_value(input logic [NUM_CH-1:0][CH_W-1:0] ch,
                                                   input logic [3:0] cmd);
        logic [CH_W-1:0] pos, neg;
        logic [CH_W:0]   diff;
        pos  = ch[{cmd[2:1], cmd[0]}];
        neg  = ch[{cmd[2:1], ~cmd[0]}];
        diff = {1'b0, pos} - {1'b0, neg};
        if (cmd[3])
            return ch[cmd[2:0]];
        return diff[CH_W] ? '0 : diff[CH_W-1:0];
    endfunction

    // Host writes land next clk; the conversion reads the post-write view so
    // a write in the latch cycle wins.
    always_comb begin
        ch_d = ch_q;
        if (wr_en)
            ch_d[wr_addr] = wr_data;
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pulse_q    <= '0;
            cmd_q      <= '0;
            sr_q       <= '0;
            dout_q     <= 1'b0;
            oe_q       <= 1'b0;
            done_q     <= 1'b0;
            sgl_q      <= 1'b0;
            ch_sel_q   <= '0;
            din_sync_q <= '0;
            for (int n = 0; n < NUM_CH; n++)
                ch_q[n] <= ch_reset_val(n);
        end else begin
            state_q    <= state_d;
            pulse_q    <= pulse_d;
            cmd_q      <= cmd_d;
            sr_q       <= sr_d;
            dout_q     <= dout_d;
            oe_q       <= oe_d;
            done_q     <= done_d;
            sgl_q      <= sgl_d;
            ch_sel_q   <= ch_sel_d;
            din_sync_q <= {din_sync_q[SYNC_STAGES-2:0], din};
            ch_q       <= ch_d;
        end
    end

    // Next state: cs_n edges override everything, then dclk-driven progress
    always_comb begin
        state_d = state_q;
        pulse_d = pulse_q;
        cmd_d   = cmd_q;
        if (cs_rise) begin
            state_d = IDLE;
        end else if (cs_fall) begin
            state_d = WAIT_START;
            pulse_d = '0;
        end else begin
            if (dclk_rise && state_q != IDLE && state_q != WAIT_START && pulse_q != '1)
                pulse_d = pulse_q + 5'd1;
            case (state_q)
                WAIT_START: if (dclk_rise && din_s) begin
                    state_d = CMD;
                    pulse_d = P_START;
                end
                CMD: if (dclk_rise) begin
                    cmd_d = {cmd_q[2:0], din_s};
                    if (pulse_q == P_D0 - 5'd1)
                        state_d = NULLB;
                end
                NULLB: if (dclk_fall && pulse_q == P_NULL)
                    state_d = MSB;
                MSB: if (dclk_fall && pulse_q == P_B0)
                    state_d = TAIL;
                default: ;
            endcase
        end
    end

    // Outputs: dout only moves on dclk falls; MSB phase rotates so the
    // shift register holds the original value again when TAIL starts.
    always_comb begin
        dout_d   = dout_q;
        oe_d     = oe_q;
        sr_d     = sr_q;
        done_d   = 1'b0;
        sgl_d    = sgl_q;
        ch_sel_d = ch_sel_q;
        if (cs_rise || cs_fall) begin
            oe_d = 1'b0;
        end else begin
            case (state_q)
                CMD: if (dclk_rise && pulse_q == P_D0 - 5'd1)
                    sr_d = conv_value(ch_d, {cmd_q[2:0], din_s});
                NULLB: if (dclk_fall && pulse_q == P_NULL) begin
                    oe_d   = 1'b1;
                    dout_d = 1'b0;
                end
                MSB: if (dclk_fall) begin
                    dout_d = sr_q[CH_W-1];
                    sr_d   = {sr_q[CH_W-2:0], sr_q[CH_W-1]};
                    if (pulse_q == P_B0) begin
                        done_d   = 1'b1;
                        ch_sel_d = cmd_q[2:0];
                        sgl_d    = cmd_q[3];
                    end
                end
                TAIL: if (dclk_fall) begin
`ifdef MCP3008_EMU_LSB_FIRST_EN
                    // Zero-fill right shift: after B9 the output naturally goes 0
                    if (pulse_q <= P_LSB_END) begin
                        dout_d = sr_q[1];
                        sr_d   = {1'b0, sr_q[CH_W-1:1]};
                    end else begin
                        dout_d = 1'b0;
                    end
`else
                    dout_d = 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

    assign dout      = dout_q;
    assign dout_oe   = oe_q;
    assign conv_done = done_q;
    assign conv_ch   = ch_sel_q;
    assign conv_sgl  = sgl_q;

endmodule
